// File: rtl/fp_norm_round_pack_if.sv
// Valid/ready bundle between the integer adder, the normalize/round/pack stage
// and its consumer.
interface fp_norm_round_pack_if #(
   parameter int MW = 32,
   parameter int EW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic          in_sign;
   logic [EW-1:0] in_exp;
   logic [MW-1:0] in_sum;
   logic          in_cout;
   logic          in_special;
   logic [31:0]   in_special_val;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_result;
   logic          out_overflow;
   logic          out_underflow;

   modport master (
      output in_valid, in_sign, in_exp, in_sum, in_cout, in_special, in_special_val,
      output out_ready,
      input  in_ready, out_valid, out_result, out_overflow, out_underflow
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_sum, in_cout, in_special, in_special_val,
      input  out_ready,
      output in_ready, out_valid, out_result, out_overflow, out_underflow
   );
endinterface

// File: rtl/fp_norm_round_pack.sv
// Three-stage normalize, round-to-nearest-even and binary32 pack stage of the
// pipelined FP adder, with bubble-collapsing valid/ready flow control.
module fp_norm_round_pack #(
   parameter int MW  = 32,
   parameter int EW  = 8,
   parameter int LAT = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   fp_norm_round_pack_if.slave bus
);
   localparam int FW  = 23;
   localparam int RW  = 1 + EW + FW;
   localparam int XW  = EW + 2;
   localparam int LZW = $clog2(MW + 1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;
   localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EW) - 1);

   logic [LAT-1:0] valid_q;
   logic [LAT-1:0] valid_d;
   logic           cap1;
   logic           cap2;
   logic           cap3;

   // A stage loads whenever it is empty or its successor is loading this cycle.
   assign cap3         = !valid_q[2] || bus.out_ready;
   assign cap2         = !valid_q[1] || cap3;
   assign cap1         = !valid_q[0] || cap2;
   assign bus.in_ready = cap1;

   always_comb begin
      valid_d = valid_q;
      if (cap1) valid_d[0] = bus.in_valid;
      if (cap2) valid_d[1] = valid_q[0];
      if (cap3) valid_d[2] = valid_q[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   logic [LZW-1:0]          lz;
   logic signed [XW-1:0]    s1Exp_d;
   logic                    s1Zero_d;
   logic                    s1StickyX_d;
   logic                    s1Sign_q;
   logic                    s1Special_q;
   logic [RW-1:0]           s1SpecialVal_q;
   logic                    s1Cout_q;
   logic [MW-1:0]           s1Sum_q;
   logic [LZW-1:0]          s1Lz_q;
   logic signed [XW-1:0]    s1Exp_q;
   logic                    s1StickyX_q;
   logic                    s1Zero_q;

   // Lowest-to-highest scan so the most significant set bit wins.
   always_comb begin
      lz = LZW'(MW);
      for (int i = 0; i < MW; i++) begin
         if (bus.in_sum[i]) lz = LZW'(MW - 1 - i);
      end
      s1Exp_d     = XW'(bus.in_exp) + XW'(bus.in_cout);
      s1Zero_d    = !bus.in_cout && (lz == LZW'(MW));
      s1StickyX_d = bus.in_cout && bus.in_sum[0];
   end

   always_ff @(posedge clk) begin
      if (cap1) begin
         s1Sign_q       <= bus.in_sign;
         s1Special_q    <= bus.in_special;
         s1SpecialVal_q <= bus.in_special_val;
         s1Cout_q       <= bus.in_cout;
         s1Sum_q        <= bus.in_sum;
         s1Lz_q         <= lz;
         s1Exp_q        <= s1Exp_d;
         s1StickyX_q    <= s1StickyX_d;
         s1Zero_q       <= s1Zero_d;
      end
   end

   logic [MW-1:0]        norm;
   logic signed [XW-1:0] s2Exp_d;
   logic [FW-1:0]        s2Frac_d;
   logic                 s2Guard_d;
   logic                 s2Sticky_d;
   logic                 s2Sign_q;
   logic                 s2Special_q;
   logic [RW-1:0]        s2SpecialVal_q;
   logic                 s2Zero_q;
   logic signed [XW-1:0] s2Exp_q;
   logic [FW-1:0]        s2Frac_q;
   logic                 s2Guard_q;
   logic                 s2Sticky_q;

   // The carry case already had its exponent bumped in stage 1.
   always_comb begin
      norm       = s1Cout_q ? {1'b1, s1Sum_q[MW-1:1]} : (s1Sum_q << s1Lz_q);
      s2Exp_d    = s1Cout_q ? s1Exp_q : (s1Exp_q - XW'(s1Lz_q));
      s2Frac_d   = norm[MW-2 -: FW];
      s2Guard_d  = norm[MW-FW-2];
      s2Sticky_d = (|norm[MW-FW-3:0]) | s1StickyX_q;
   end

   always_ff @(posedge clk) begin
      if (cap2) begin
         s2Sign_q       <= s1Sign_q;
         s2Special_q    <= s1Special_q;
         s2SpecialVal_q <= s1SpecialVal_q;
         s2Zero_q       <= s1Zero_q;
         s2Exp_q        <= s2Exp_d;
         s2Frac_q       <= s2Frac_d;
         s2Guard_q      <= s2Guard_d;
         s2Sticky_q     <= s2Sticky_d;
      end
   end

   logic                 roundUp;
   logic [FW:0]          fracR;
   logic signed [XW-1:0] expR;
   logic [RW-1:0]        result_d;
   logic                 ovf_d;
   logic                 unf_d;
   logic [RW-1:0]        result_q;
   logic                 ovf_q;
   logic                 unf_q;

   // A mantissa carry leaves fracR[FW-1:0] at zero, so only the exponent moves.
   always_comb begin
      roundUp  = s2Guard_q && (s2Sticky_q || s2Frac_q[0]);
      fracR    = {1'b0, s2Frac_q} + {{FW{1'b0}}, roundUp};
      expR     = s2Exp_q + {{(XW-1){1'b0}}, fracR[FW]};
      result_d = {s2Sign_q, expR[EW-1:0], fracR[FW-1:0]};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      if (s2Special_q) begin
         result_d = s2SpecialVal_q;
      end else if (s2Zero_q) begin
         result_d = '0;
      end else if (s2Exp_q <= EXP_ZERO) begin
         result_d = {s2Sign_q, {(RW-1){1'b0}}};
         unf_d    = 1'b1;
      end else if (expR >= EXP_MAX) begin
         result_d = {s2Sign_q, {EW{1'b1}}, {FW{1'b0}}};
         ovf_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else if (cap3) begin
         result_q <= result_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign bus.out_valid     = valid_q[2];
   assign bus.out_result    = result_q;
   assign bus.out_overflow  = ovf_q;
   assign bus.out_underflow = unf_q;
endmodule

// File: tb/tb_fp_norm_round_pack.sv
// Self-checking bench for fp_norm_round_pack: vector table driven through a
// scoreboard, plus latency, backpressure and mid-stream reset sequences.
module tb_fp_norm_round_pack;
   typedef struct packed {
      logic        sign;
      logic [7:0]  expIn;
      logic        cout;
      logic [31:0] sum;
      logic        special;
      logic [31:0] spv;
      logic [31:0] res;
      logic        ovf;
      logic        unf;
   } vec_t;

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
   } exp_t;

   localparam int NV = 17;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   vec_t vecs [NV];
   exp_t sbq [$];
   int   checks = 0;
   int   errors = 0;
   int   outCount = 0;

   always #5 clk = ~clk;

   fp_norm_round_pack_if #(.MW(32), .EW(8)) ifc ();

   fp_norm_round_pack #(.MW(32), .EW(8), .LAT(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   function automatic vec_t mkVec(logic s, logic [7:0] e, logic c, logic [31:0] sm,
                                  logic sp, logic [31:0] spv, logic [31:0] r,
                                  logic o, logic u);
      return {s, e, c, sm, sp, spv, r, o, u};
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Drives one record, waits (bounded) for acceptance and logs its expectation.
   task automatic applyStimulus(vec_t v);
      logic rdy;
      bit   accepted;
      accepted           = 1'b0;
      ifc.in_valid       = 1'b1;
      ifc.in_sign        = v.sign;
      ifc.in_exp         = v.expIn;
      ifc.in_cout        = v.cout;
      ifc.in_sum         = v.sum;
      ifc.in_special     = v.special;
      ifc.in_special_val = v.spv;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         rdy = ifc.in_ready;
         @(posedge clk);
         if (rdy) begin
            sbq.push_back({v.res, v.ovf, v.unf});
            accepted = 1'b1;
            break;
         end
      end
      #1 ifc.in_valid = 1'b0;
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, expected acceptance");
      end
   endtask

   task automatic waitDrain();
      for (int c = 0; c < 300 && sbq.size() != 0; c++) @(negedge clk);
      checkOutput("drain_pending", 32'(sbq.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard pop on each transfer, stability check while stalled.
   exp_t held;
   logic stalled = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            checkOutput("hold_valid", 32'(ifc.out_valid), 32'd1);
            checkOutput("hold_result", ifc.out_result, held.res);
            checkOutput("hold_ovf", 32'(ifc.out_overflow), 32'(held.ovf));
            checkOutput("hold_unf", 32'(ifc.out_underflow), 32'(held.unf));
         end
         if (ifc.out_valid && ifc.out_ready) begin
            outCount++;
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output: got %h, expected no output", ifc.out_result);
            end else begin
               e = sbq.pop_front();
               checkOutput("result", ifc.out_result, e.res);
               checkOutput("overflow", 32'(ifc.out_overflow), 32'(e.ovf));
               checkOutput("underflow", 32'(ifc.out_underflow), 32'(e.unf));
            end
         end
         stalled = ifc.out_valid && !ifc.out_ready;
         held    = {ifc.out_result, ifc.out_overflow, ifc.out_underflow};
      end
   end

   initial begin
      int  lat;
      int  base;
      bit  sawNotReady;
      bit  done;

      vecs[0]  = mkVec(0, 8'd127, 1, 32'h0000_0000, 0, 32'h0, 32'h4000_0000, 0, 0);
      vecs[1]  = mkVec(0, 8'd127, 0, 32'h0080_0000, 0, 32'h0, 32'h3B80_0000, 0, 0);
      vecs[2]  = mkVec(0, 8'd8,   0, 32'h0080_0000, 0, 32'h0, 32'h0000_0000, 0, 1);
      vecs[3]  = mkVec(0, 8'd127, 0, 32'h8000_0180, 0, 32'h0, 32'h3F80_0002, 0, 0);
      vecs[4]  = mkVec(0, 8'd127, 0, 32'h8000_0080, 0, 32'h0, 32'h3F80_0000, 0, 0);
      vecs[5]  = mkVec(0, 8'd127, 0, 32'h8000_00C0, 0, 32'h0, 32'h3F80_0001, 0, 0);
      vecs[6]  = mkVec(0, 8'd127, 0, 32'hFFFF_FF80, 0, 32'h0, 32'h4000_0000, 0, 0);
      vecs[7]  = mkVec(0, 8'd254, 1, 32'h0000_0000, 0, 32'h0, 32'h7F80_0000, 1, 0);
      vecs[8]  = mkVec(1, 8'd254, 0, 32'h0000_0000, 0, 32'h0, 32'h0000_0000, 0, 0);
      vecs[9]  = mkVec(0, 8'd254, 1, 32'h0000_0000, 1, 32'h7FC0_0000, 32'h7FC0_0000, 0, 0);
      vecs[10] = mkVec(1, 8'd127, 0, 32'h8000_0000, 0, 32'h0, 32'hBF80_0000, 0, 0);
      vecs[11] = mkVec(1, 8'd3,   0, 32'h0080_0000, 0, 32'h0, 32'h8000_0000, 0, 1);
      vecs[12] = mkVec(0, 8'd127, 1, 32'h0000_0101, 0, 32'h0, 32'h4000_0001, 0, 0);
      vecs[13] = mkVec(0, 8'd127, 0, 32'h0000_0001, 0, 32'h0, 32'h3000_0000, 0, 0);
      vecs[14] = mkVec(0, 8'd254, 0, 32'hFFFF_FF80, 0, 32'h0, 32'h7F80_0000, 1, 0);
      vecs[15] = mkVec(1, 8'd1,   0, 32'h4000_0000, 0, 32'h0, 32'h8000_0000, 0, 1);
      vecs[16] = mkVec(1, 8'd2,   0, 32'h4000_0000, 0, 32'h0, 32'h8080_0000, 0, 0);

      ifc.in_valid       = 1'b0;
      ifc.in_sign        = 1'b0;
      ifc.in_exp         = '0;
      ifc.in_cout        = 1'b0;
      ifc.in_sum         = '0;
      ifc.in_special     = 1'b0;
      ifc.in_special_val = '0;
      ifc.out_ready      = 1'b1;

      #12;
      checkOutput("reset_out_valid", 32'(ifc.out_valid), 32'd0);
      checkOutput("reset_out_result", ifc.out_result, 32'd0);
      checkOutput("reset_ovf", 32'(ifc.out_overflow), 32'd0);
      checkOutput("reset_unf", 32'(ifc.out_underflow), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_in_ready", 32'(ifc.in_ready), 32'd1);

      $display("[TB] latency of a single transaction");
      applyStimulus(vecs[0]);
      lat = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         lat++;
         if (ifc.out_valid) break;
      end
      checkOutput("latency", 32'(lat), 32'd3);
      waitDrain();

      $display("[TB] vector table, back-to-back, out_ready high");
      base = outCount;
      for (int i = 0; i < NV; i++) applyStimulus(vecs[i]);
      waitDrain();
      checkOutput("table_out_count", 32'(outCount - base), 32'(NV));

      $display("[TB] vector table under random out_ready");
      done = 1'b0;
      base = outCount;
      fork
         begin
            for (int i = 0; i < NV; i++) applyStimulus(vecs[i]);
            waitDrain();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 ifc.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      ifc.out_ready = 1'b1;
      checkOutput("random_out_count", 32'(outCount - base), 32'(NV));

      $display("[TB] backpressure stream of six");
      base = outCount;
      sawNotReady = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) applyStimulus(vecs[3 + i]);
         end
         begin
            @(posedge clk);
            #1 ifc.out_ready = 1'b0;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               if (!ifc.in_ready) sawNotReady = 1'b1;
            end
            @(posedge clk);
            #1 ifc.out_ready = 1'b1;
         end
      join
      waitDrain();
      checkOutput("bp_in_ready_dropped", 32'(sawNotReady), 32'd1);
      checkOutput("bp_out_count", 32'(outCount - base), 32'd6);

      $display("[TB] reset with transactions in flight");
      ifc.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_out_valid", 32'(ifc.out_valid), 32'd0);
      checkOutput("midreset_out_result", ifc.out_result, 32'd0);
      sbq.delete();
      base = outCount;
      #10;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_in_ready", 32'(ifc.in_ready), 32'd1);
      ifc.out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("midreset_no_stale", 32'(outCount - base), 32'd0);
      checkOutput("midreset_idle_valid", 32'(ifc.out_valid), 32'd0);

      applyStimulus(vecs[16]);
      applyStimulus(vecs[12]);
      waitDrain();
      checkOutput("post_reset_out_count", 32'(outCount - base), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_norm_round_pack.md
Name: fp_norm_round_pack

Overview:
- Downstream stage of the pipelined single-precision FP adder; consumes the magnitude sum and carry produced by the pipelined recursive-doubling integer adder.
- Normalizes the sum (overflow right-shift or leading-zero left-shift) and rounds to nearest-even.
- Packs an IEEE-754 binary32 result, with overflow and underflow flags.
- 3-stage valid/ready pipeline, throughput 1 result/cycle.

Parameters:
- MW, 32: width of the incoming mantissa sum (hidden bit at MW-1, guard at MW-25, sticky field below it).
- EW, 8: biased exponent width.
- LAT, 3: pipeline depth. Fixed; documents the latency only.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  stage can accept this cycle.
- in_sign  in  1  sign of the result (from alignment stage).
- in_exp  in  EW  biased exponent of the larger operand.
- in_sum  in  MW  magnitude sum from the adder.
- in_cout  in  1  adder carry-out; {in_cout,in_sum} is the 33-bit magnitude.
- in_special  in  1  upstream detected NaN/Inf operand; bypass normalization.
- in_special_val  in  32  packed result to pass through when in_special=1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  32  packed binary32 result.
- out_overflow  out  1  result rounded to infinity.
- out_underflow  out  1  result flushed to zero (denormals not supported).

Behaviour:
- Reset (rst_n low, any time, asynchronous): all stage valids=0, out_valid=0, out_result=0, out_overflow=0, out_underflow=0. in_ready=1 after reset. In-flight data is discarded.
- Handshake: a transfer occurs when valid&&ready on either side. Stage k captures when !valid_k or stage k+1 captures (bubble-collapsing). Stage 3 captures when !out_valid or out_ready. in_ready = stage-1 capture condition.
- Holding rule: out_* hold stable while out_valid && !out_ready. No loss or duplication under any ready pattern.
- Latency: 3 cycles from input accept to out_valid when out_ready=1.
- S1 (detect):
  - If in_cout=1, register shift-right-1: exp = in_exp+1, sticky_extra = in_sum[0].
  - Otherwise compute lz = leading-zero count of in_sum (0..32). lz=32 flags an exact zero.
  - Internal exponent is 10-bit signed.
- S2 (shift):
  - Produce N[31:0] with N[31]=1: N = {1,in_sum[31:1]} for the cout case, else in_sum<<lz.
  - exp_n = in_exp+1 for the cout case, else in_exp-lz.
  - frac = N[30:8], guard = N[7], sticky = |N[6:0] | sticky_extra.
- S3 (round/pack), in priority order:
  - in_special → out_result = in_special_val, both flags 0.
  - Exact zero → +0 (0x00000000), flags 0.
  - exp_n <= 0 → signed zero {sign, 31'b0}, out_underflow=1.
  - Otherwise round up when guard && (sticky || frac[0]). If frac+1 carries out, frac=0 and exp_n+1.
  - Final exp >= 255 → {sign, 8'hFF, 23'b0}, out_overflow=1.
  - Else {sign, exp[7:0], frac}.
- Sideband travels unmodified with its transaction through every stage: in_sign, in_special, in_special_val.
- Simultaneous stage-3 drain and stage-1 accept in one cycle is legal and required for full throughput.

Test Plan:
- in_sign=0, in_exp=127, in_cout=1, in_sum=0 (1.0+1.0) → after 3 cycles out_result=0x40000000, flags 0.
- in_exp=127, in_cout=0, in_sum=0x00800000 (lz=8) → out_result=0x3B800000. Same inputs with in_exp=8 → out_result=0x00000000, out_underflow=1.
- Rounding ties, in_exp=127, in_cout=0:
  - in_sum=0x80000180 → 0x3F800002 (tie, odd LSB, rounds up).
  - in_sum=0x80000080 → 0x3F800000 (tie, even, stays).
  - in_sum=0x800000C0 → 0x3F800001 (above half).
  - in_sum=0xFFFFFF80 → 0x40000000 (mantissa carry bumps exponent).
- in_exp=254, in_cout=1, in_sum=0 → 0x7F800000, out_overflow=1. in_cout=0, in_sum=0 → 0x00000000. in_special=1, in_special_val=0x7FC00000 → 0x7FC00000.
- Backpressure stream: 6 back-to-back inputs, out_ready low cycles 2-6 → in_ready drops once 3 entries are held, outputs stable while stalled, all 6 results emerge in order exactly once.
- Reset mid-stream: assert rst_n low with 3 transactions in flight → out_valid=0 immediately (asynchronous), in_ready=1 after release, no stale result emerges.
